// File: rtl/flu_tx_shaper_ctrl_pkg.sv
// flu_tx_shaper_ctrl_pkg: shared FSM state type and SOP byte-offset helper
package flu_tx_shaper_ctrl_pkg;
  typedef enum logic [1:0] {ST_STOPPED, ST_IDLE, ST_IN_FRAME, ST_DRAIN} fsm_state_t;
  function automatic logic [31:0] sop_byte(input logic [31:0] sop_pos, input logic [31:0] sb);
    return sop_pos * sb;
  endfunction
endpackage

// File: rtl/flu_token_bucket.sv
// flu_token_bucket: signed byte-credit bucket with saturating refill and per-word cost
module flu_token_bucket #(
  parameter int WB = 64,
  parameter int CREDIT_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shaper_en,
  input  logic [15:0]             rate_inc,
  input  logic [CREDIT_WIDTH-2:0] bucket_max,
  input  logic                    acc,
  output logic                    neg
);
  localparam int CW = CREDIT_WIDTH + 1;
  logic signed [CREDIT_WIDTH-1:0] credit_q;
  logic signed [CW-1:0] sum, max_v, cap_v, credit_next;
  // refill first, saturate at the ceiling, then charge a full word if one was accepted
  always_comb begin
    max_v = $signed(CW'(bucket_max));
    sum = CW'(credit_q) + $signed(CW'(rate_inc));
    cap_v = (sum > max_v) ? max_v : sum;
    credit_next = cap_v - $signed(CW'(acc ? WB : 0));
  end
  // with shaping off the bucket sits full so enabling it starts from a full burst
  always_ff @(posedge clk or posedge rst)
    if (rst) credit_q <= '0;
    else credit_q <= shaper_en ? CREDIT_WIDTH'(credit_next) : $signed(CREDIT_WIDTH'(bucket_max));
  assign neg = credit_q[CREDIT_WIDTH-1];
endmodule

// File: rtl/flu_tx_shaper_ctrl.sv
// flu_tx_shaper_ctrl: frame-boundary enable gate and byte-rate shaper on the FLU handshake
module flu_tx_shaper_ctrl
  import flu_tx_shaper_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int SOP_POS_WIDTH = 3,
  parameter int CREDIT_WIDTH = 24
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              CFG_ENABLE,
  input  logic                              CFG_SHAPER_EN,
  input  logic [15:0]                       CFG_RATE_INC,
  input  logic [CREDIT_WIDTH-2:0]           CFG_BUCKET_MAX,
  input  logic [DATA_WIDTH-1:0]             RX_DATA,
  input  logic [SOP_POS_WIDTH-1:0]          RX_SOP_POS,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   RX_EOP_POS,
  input  logic                              RX_SOP,
  input  logic                              RX_EOP,
  input  logic                              RX_SRC_RDY,
  output logic                              RX_DST_RDY,
  output logic [DATA_WIDTH-1:0]             TX_DATA,
  output logic [SOP_POS_WIDTH-1:0]          TX_SOP_POS,
  output logic [$clog2(DATA_WIDTH/8)-1:0]   TX_EOP_POS,
  output logic                              TX_SOP,
  output logic                              TX_EOP,
  output logic                              TX_SRC_RDY,
  input  logic                              TX_DST_RDY,
  input  logic                              STAT_CLR,
  output logic                              STAT_STOPPED,
  output logic [31:0]                       STAT_FRAMES
);
  localparam int WB = DATA_WIDTH / 8;
  localparam int SB = WB / (2 ** SOP_POS_WIDTH);
  fsm_state_t state, state_next;
  logic open_q, open_next, block, acc, credit_neg;
  flu_token_bucket #(.WB(WB), .CREDIT_WIDTH(CREDIT_WIDTH)) u_bucket (
    .clk(CLK),
    .rst(RESET),
    .shaper_en(CFG_SHAPER_EN),
    .rate_inc(CFG_RATE_INC),
    .bucket_max(CFG_BUCKET_MAX),
    .acc(acc),
    .neg(credit_neg)
  );
  assign block = (~open_q & ~CFG_ENABLE) | (CFG_SHAPER_EN & credit_neg);
  assign acc = RX_SRC_RDY & TX_DST_RDY & ~block;
  assign TX_SRC_RDY = RX_SRC_RDY & ~block;
  assign RX_DST_RDY = TX_DST_RDY & ~block;
  assign TX_DATA = RX_DATA;
  assign TX_SOP_POS = RX_SOP_POS;
  assign TX_EOP_POS = RX_EOP_POS;
  assign TX_SOP = RX_SOP;
  assign TX_EOP = RX_EOP;
  assign STAT_STOPPED = state == ST_STOPPED;
  // a word with SOP placed after its EOP closes one frame and opens the next
  always_comb begin
    open_next = open_q;
    if (acc) open_next = RX_SOP ? (~RX_EOP | (sop_byte(32'(RX_SOP_POS), SB) > 32'(RX_EOP_POS))) : (open_q & ~RX_EOP);
    state_next = open_next ? (CFG_ENABLE ? ST_IN_FRAME : ST_DRAIN) : (CFG_ENABLE ? ST_IDLE : ST_STOPPED);
  end
  // frame state, open flag and frame counter; clear beats a simultaneous increment
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= ST_STOPPED;
      open_q <= 1'b0;
      STAT_FRAMES <= '0;
    end else begin
      state <= state_next;
      open_q <= open_next;
      STAT_FRAMES <= STAT_CLR ? '0 : STAT_FRAMES + 32'(acc & RX_EOP);
    end
endmodule

// File: tb/tb_flu_tx_shaper_ctrl.sv
// tb_flu_tx_shaper_ctrl: directed scoreboard bench for the FLU admission controller
module tb_flu_tx_shaper_ctrl;
  import flu_tx_shaper_ctrl_pkg::*;
  typedef struct packed {
    logic [63:0] tag;
    logic sop;
    logic eop;
    logic [2:0] sp;
    logic [5:0] ep;
  } word_t;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic CFG_ENABLE = 1'b0, CFG_SHAPER_EN = 1'b0;
  logic [15:0] CFG_RATE_INC = 16'd16;
  logic [22:0] CFG_BUCKET_MAX = 23'd64;
  logic [511:0] RX_DATA = '0, TX_DATA;
  logic [2:0] RX_SOP_POS = '0, TX_SOP_POS;
  logic [5:0] RX_EOP_POS = '0, TX_EOP_POS;
  logic RX_SOP = 1'b0, RX_EOP = 1'b0, RX_SRC_RDY = 1'b1, RX_DST_RDY;
  logic TX_SOP, TX_EOP, TX_SRC_RDY, TX_DST_RDY = 1'b1;
  logic STAT_CLR = 1'b0, STAT_STOPPED;
  logic [31:0] STAT_FRAMES;
  word_t sb_q[$];
  int checks = 0, errors = 0, exp_frames = 0;

  flu_tx_shaper_ctrl dut (
    .CLK(CLK), .RESET(RESET), .CFG_ENABLE(CFG_ENABLE), .CFG_SHAPER_EN(CFG_SHAPER_EN),
    .CFG_RATE_INC(CFG_RATE_INC), .CFG_BUCKET_MAX(CFG_BUCKET_MAX),
    .RX_DATA(RX_DATA), .RX_SOP_POS(RX_SOP_POS), .RX_EOP_POS(RX_EOP_POS), .RX_SOP(RX_SOP),
    .RX_EOP(RX_EOP), .RX_SRC_RDY(RX_SRC_RDY), .RX_DST_RDY(RX_DST_RDY),
    .TX_DATA(TX_DATA), .TX_SOP_POS(TX_SOP_POS), .TX_EOP_POS(TX_EOP_POS), .TX_SOP(TX_SOP),
    .TX_EOP(TX_EOP), .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY),
    .STAT_CLR(STAT_CLR), .STAT_STOPPED(STAT_STOPPED), .STAT_FRAMES(STAT_FRAMES)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic sop, input logic eop, input logic [2:0] sp, input logic [5:0] ep);
    word_t w;
    w.tag = {$urandom, $urandom};
    w.sop = sop;
    w.eop = eop;
    w.sp = sp;
    w.ep = ep;
    RX_DATA = {8{w.tag}};
    RX_SOP = sop;
    RX_EOP = eop;
    RX_SOP_POS = sp;
    RX_EOP_POS = ep;
    RX_SRC_RDY = 1'b1;
    sb_q.push_back(w);
    if (eop) exp_frames++;
  endtask

  task automatic wait_accept(output int waited);
    word_t w;
    waited = 0;
    #1;
    while (!(RX_DST_RDY && TX_SRC_RDY && TX_DST_RDY) && waited < 200) begin
      @(negedge CLK);
      #1;
      waited++;
    end
    checks++;
    assert (waited < 200) else begin
      errors++;
      $error("FAIL accept_timeout observed=%0d expected=<200", waited);
    end
    w = sb_q.pop_front();
    chk("tx_data", TX_DATA[63:0], w.tag);
    chk("tx_flags", {TX_SOP, TX_EOP, TX_SOP_POS, TX_EOP_POS}, {w.sop, w.eop, w.sp, w.ep});
    @(negedge CLK);
  endtask

  task automatic send(input logic sop, input logic eop, input logic [2:0] sp, input logic [5:0] ep, output int waited);
    drive(sop, eop, sp, ep);
    wait_accept(waited);
  endtask

  initial begin
    int w, sum_w, c, e;
    repeat (3) @(negedge CLK);
    chk("rst_credit", dut.u_bucket.credit_q, 0);
    chk("rst_tx_src_rdy", TX_SRC_RDY, 0);
    RESET = 1'b0;
    @(negedge CLK);
    #1;
    chk("rst_tx_src_rdy_after", TX_SRC_RDY, 0);
    chk("rst_rx_dst_rdy", RX_DST_RDY, 0);
    chk("rst_stopped", STAT_STOPPED, 1);
    chk("rst_frames", STAT_FRAMES, 0);
    @(negedge CLK);
    RX_SRC_RDY = 1'b0;
    CFG_ENABLE = 1'b1;
    sum_w = 0;
    for (int f = 0; f < 10; f++)
      for (int k = 0; k < 3; k++) begin
        send(k == 0, k == 2, 3'd0, 6'd63, w);
        sum_w += w;
      end
    chk("b2b_stalls", sum_w, 0);
    chk("b2b_frames", STAT_FRAMES, exp_frames);
    chk("b2b_state_idle", dut.state, ST_IDLE);
    chk("b2b_not_stopped", STAT_STOPPED, 0);
    drive(1'b1, 1'b1, 3'd0, 6'd63);
    TX_DST_RDY = 1'b0;
    #1;
    chk("bp_rx_dst_rdy", RX_DST_RDY, 0);
    chk("bp_tx_src_rdy", TX_SRC_RDY, 1);
    @(negedge CLK);
    TX_DST_RDY = 1'b1;
    wait_accept(w);
    chk("bp_frames", STAT_FRAMES, exp_frames);
    send(1'b1, 1'b0, 3'd0, 6'd63, w);
    CFG_ENABLE = 1'b0;
    send(1'b0, 1'b0, 3'd0, 6'd63, w);
    chk("drain_w2_stall", w, 0);
    chk("drain_state", dut.state, ST_DRAIN);
    send(1'b0, 1'b0, 3'd0, 6'd63, w);
    chk("drain_w3_stall", w, 0);
    send(1'b0, 1'b1, 3'd0, 6'd63, w);
    chk("drain_w4_stall", w, 0);
    chk("drain_stopped", STAT_STOPPED, 1);
    drive(1'b1, 1'b0, 3'd0, 6'd63);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("held_rx_dst_rdy", RX_DST_RDY, 0);
      chk("held_tx_src_rdy", TX_SRC_RDY, 0);
      @(negedge CLK);
    end
    CFG_ENABLE = 1'b1;
    wait_accept(w);
    chk("reenable_stall", w, 0);
    send(1'b0, 1'b1, 3'd0, 6'd10, w);
    chk("drain_frames", STAT_FRAMES, exp_frames);
    send(1'b1, 1'b0, 3'd0, 6'd63, w);
    CFG_ENABLE = 1'b0;
    send(1'b1, 1'b1, 3'd4, 6'd20, w);
    chk("leak_accept_stall", w, 0);
    chk("leak_state_drain", dut.state, ST_DRAIN);
    send(1'b0, 1'b1, 3'd0, 6'd10, w);
    chk("leak_tail_stall", w, 0);
    chk("leak_stopped", STAT_STOPPED, 1);
    chk("leak_frames", STAT_FRAMES, exp_frames);
    CFG_ENABLE = 1'b1;
    send(1'b1, 1'b1, 3'd2, 6'd20, w);
    chk("single_word_state_idle", dut.state, ST_IDLE);
    chk("single_word_frames", STAT_FRAMES, exp_frames);
    RX_SRC_RDY = 1'b0;
    @(negedge CLK);
    CFG_SHAPER_EN = 1'b1;
    c = 64;
    for (int i = 0; i < 12; i++) begin
      send(1'b1, 1'b1, 3'd0, 6'd63, w);
      e = 0;
      while (c < 0) begin
        c = (c + 16 > 64) ? 64 : c + 16;
        e++;
      end
      c = ((c + 16 > 64) ? 64 : c + 16) - 64;
      chk("shaper_wait", w, e);
      chk("shaper_credit", dut.u_bucket.credit_q, c);
      chk("shaper_floor", $signed(dut.u_bucket.credit_q) >= -64, 1);
    end
    chk("shaper_steady_wait", w, 3);
    CFG_SHAPER_EN = 1'b0;
    STAT_CLR = 1'b1;
    send(1'b1, 1'b1, 3'd0, 6'd63, w);
    STAT_CLR = 1'b0;
    exp_frames = 0;
    chk("clr_wins", STAT_FRAMES, exp_frames);
    send(1'b1, 1'b1, 3'd0, 6'd63, w);
    chk("post_clr_frames", STAT_FRAMES, exp_frames);
    RX_SRC_RDY = 1'b0;
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
